branch_resolve: RTL and testbench

Parametrised branch resolution stage for the 32-bit RISC pipeline, generalising single-operand zero detection to eight compare modes with registered outputs. Sits between operand read and PC update. Evaluates the branch condition and computes the target PC. On a taken branch it issues a one-cycle redirect and holds a flush window that squashes younger instructions. Maintains saturating branch and taken counters for debug.

---
 rtl/branch_pkg.sv | 28 ++
 rtl/branch_resolve_if.sv | 31 +++
 rtl/branch_cond.sv | 37 +++
 rtl/branch_resolve.sv | 115 +++++++++++
 tb/tb_branch_resolve.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch resolution stage.
package branch_pkg;

  localparam int unsigned SAT_W = 32;

  typedef enum logic [2:0] {
    MODE_EQZ = 3'd0,
    MODE_NEZ = 3'd1,
    MODE_LTZ = 3'd2,
    MODE_GEZ = 3'd3,
    MODE_EQ  = 3'd4,
    MODE_NE  = 3'd5,
    MODE_LT  = 3'd6,
    MODE_GE  = 3'd7
  } mode_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_e;

  // Increment that sticks at max instead of wrapping; callers widen to SAT_W.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] v,
                                               input logic [SAT_W-1:0] max);
    return (v >= max) ? v : v + SAT_W'(1);
  endfunction

endpackage

// File: rtl/branch_resolve_if.sv
// Branch request / result bundle between operand read, this stage and fetch.
interface branch_resolve_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic [2:0]       in_mode;
  logic [XLEN-1:0]  in_rs1;
  logic [XLEN-1:0]  in_rs2;
  logic [XLEN-1:0]  in_pc;
  logic [XLEN-1:0]  in_offset;
  logic             out_valid;
  logic             out_taken;
  logic [XLEN-1:0]  out_target;
  logic             redirect;
  logic             flush;
  logic [CNT_W-1:0] stat_branches;
  logic [CNT_W-1:0] stat_taken;

  modport master (
    output in_valid, in_mode, in_rs1, in_rs2, in_pc, in_offset,
    input  out_valid, out_taken, out_target, redirect, flush,
           stat_branches, stat_taken
  );

  modport slave (
    input  in_valid, in_mode, in_rs1, in_rs2, in_pc, in_offset,
    output out_valid, out_taken, out_target, redirect, flush,
           stat_branches, stat_taken
  );
endinterface

// File: rtl/branch_cond.sv
// Combinational branch condition: decodes the compare mode and evaluates rs1/rs2.
module branch_cond
  import branch_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mode_e           mode_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            cond_o
);

  logic is_zero;
  logic is_neg;
  logic is_eq;
  logic is_lt;

  always_comb begin
    is_zero = (rs1_i == '0);
    is_neg  = rs1_i[XLEN-1];
    is_eq   = (rs1_i == rs2_i);
    is_lt   = ($signed(rs1_i) < $signed(rs2_i));
    cond_o  = 1'b0;
    case (mode_i)
      MODE_EQZ: cond_o = is_zero;
      MODE_NEZ: cond_o = !is_zero;
      MODE_LTZ: cond_o = is_neg;
      MODE_GEZ: cond_o = !is_neg;
      MODE_EQ:  cond_o = is_eq;
      MODE_NE:  cond_o = !is_eq;
      MODE_LT:  cond_o = is_lt;
      MODE_GE:  cond_o = !is_lt;
      default:  cond_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// Branch resolution stage: registers the condition and target, issues redirect,
// holds a squash window after taken branches and keeps saturating statistics.
module branch_resolve
  import branch_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic             clk,
  input logic             rst,
  branch_resolve_if.slave bus
);

  localparam int unsigned FCW        = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES);
  // Counters are widened to SAT_W for the shared helper; CNT_W must not exceed it.
  localparam logic [SAT_W-1:0] CNT_MAX  = SAT_W'((64'd1 << CNT_W) - 64'd1);

  state_e            state_q, state_d;
  logic [FCW-1:0]    fcnt_q, fcnt_d;
  logic              valid_q, valid_d;
  logic              taken_q, taken_d;
  logic [XLEN-1:0]   target_q, target_d;
  logic              redirect_q, redirect_d;
  logic              flush_q, flush_d;
  logic [CNT_W-1:0]  br_q, br_d;
  logic [CNT_W-1:0]  tk_q, tk_d;

  logic              cond_c;
  logic [XLEN-1:0]   target_c;

  branch_cond #(.XLEN(XLEN)) u_cond (
    .mode_i (mode_e'(bus.in_mode)),
    .rs1_i  (bus.in_rs1),
    .rs2_i  (bus.in_rs2),
    .cond_o (cond_c)
  );

  assign target_c = bus.in_pc + bus.in_offset;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fcnt_q     <= '0;
      valid_q    <= 1'b0;
      taken_q    <= 1'b0;
      target_q   <= '0;
      redirect_q <= 1'b0;
      flush_q    <= 1'b0;
      br_q       <= '0;
      tk_q       <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      valid_q    <= valid_d;
      taken_q    <= taken_d;
      target_q   <= target_d;
      redirect_q <= redirect_d;
      flush_q    <= flush_d;
      br_q       <= br_d;
      tk_q       <= tk_d;
    end
  end

  // Next-state: accept in IDLE, squash everything while the window is open.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    valid_d    = 1'b0;
    taken_d    = taken_q;
    target_d   = target_q;
    redirect_d = 1'b0;
    flush_d    = flush_q;
    br_d       = br_q;
    tk_d       = tk_q;
    case (state_q)
      ST_IDLE: begin
        flush_d = 1'b0;
        if (bus.in_valid) begin
          valid_d  = 1'b1;
          taken_d  = cond_c;
          target_d = target_c;
          br_d     = CNT_W'(sat_inc(SAT_W'(br_q), CNT_MAX));
          if (cond_c) begin
            redirect_d = 1'b1;
            flush_d    = 1'b1;
            tk_d       = CNT_W'(sat_inc(SAT_W'(tk_q), CNT_MAX));
            fcnt_d     = FLUSH_LOAD;
            state_d    = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        fcnt_d = fcnt_q - FCW'(1);
        if (fcnt_q == FCW'(1)) begin
          flush_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.out_valid     = valid_q;
  assign bus.out_taken     = taken_q;
  assign bus.out_target    = target_q;
  assign bus.redirect      = redirect_q;
  assign bus.flush         = flush_q;
  assign bus.stat_branches = br_q;
  assign bus.stat_taken    = tk_q;

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: mode table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_branch_resolve;

  localparam int unsigned FC = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  branch_resolve_if #(.XLEN(32), .CNT_W(16)) bus ();
  branch_resolve_if #(.XLEN(32), .CNT_W(4))  bus4 ();

  assign bus4.in_valid  = bus.in_valid;
  assign bus4.in_mode   = bus.in_mode;
  assign bus4.in_rs1    = bus.in_rs1;
  assign bus4.in_rs2    = bus.in_rs2;
  assign bus4.in_pc     = bus.in_pc;
  assign bus4.in_offset = bus.in_offset;

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  branch_resolve #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dut4 (
    .clk (clk), .rst (rst), .bus (bus4)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: squash window as a plain countdown of remaining cycles.
  int          sq = 0;
  logic        m_valid = 1'b0, m_taken = 1'b0, m_red = 1'b0, m_flush = 1'b0;
  logic [31:0] m_target = '0;
  int          m_br = 0, m_tk = 0, m_br4 = 0, m_tk4 = 0;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] rs1;
    logic        exp;
  } vec_t;

  function automatic logic ref_cond(input logic [2:0] mode, input logic [31:0] a,
                                    input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    case (mode)
      3'd0: return a == 0;
      3'd1: return a != 0;
      3'd2: return sa < 0;
      3'd3: return sa >= 0;
      3'd4: return a == b;
      3'd5: return a != b;
      3'd6: return sa < sb;
      default: return sa >= sb;
    endcase
  endfunction

  function automatic int sat(input int v, input int max);
    return (v < max) ? v + 1 : v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] mode, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pc, input logic [31:0] off);
    bus.in_valid  = v;
    bus.in_mode   = mode;
    bus.in_rs1    = rs1;
    bus.in_rs2    = rs2;
    bus.in_pc     = pc;
    bus.in_offset = off;
  endtask

  task automatic model_step();
    logic c;
    if (rst) begin
      sq = 0; m_valid = 0; m_taken = 0; m_red = 0; m_flush = 0; m_target = '0;
      m_br = 0; m_tk = 0; m_br4 = 0; m_tk4 = 0;
    end else if (sq > 0) begin
      m_valid = 0; m_red = 0;
      sq--;
      m_flush = (sq > 0);
    end else if (bus.in_valid) begin
      c = ref_cond(bus.in_mode, bus.in_rs1, bus.in_rs2);
      m_valid = 1; m_taken = c;
      m_target = bus.in_pc + bus.in_offset;
      m_br = sat(m_br, 65535); m_br4 = sat(m_br4, 15);
      if (c) begin
        m_tk = sat(m_tk, 65535); m_tk4 = sat(m_tk4, 15);
        m_red = 1; m_flush = 1; sq = FC;
      end else begin
        m_red = 0; m_flush = 0;
      end
    end else begin
      m_valid = 0; m_red = 0; m_flush = 0;
    end
  endtask

  // One clock: advance the model, let the edge pass, compare every output.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 64'(bus.out_valid), 64'(m_valid));
    chk("taken", 64'(bus.out_taken), 64'(m_taken));
    chk("target", 64'(bus.out_target), 64'(m_target));
    chk("redirect", 64'(bus.redirect), 64'(m_red));
    chk("flush", 64'(bus.flush), 64'(m_flush));
    chk("stat_branches", 64'(bus.stat_branches), 64'(m_br));
    chk("stat_taken", 64'(bus.stat_taken), 64'(m_tk));
    chk("stat_branches4", 64'(bus4.stat_branches), 64'(m_br4));
    chk("stat_taken4", 64'(bus4.stat_taken), 64'(m_tk4));
  endtask

  task automatic idle(input int n);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    repeat (n) tick();
  endtask

  vec_t        tbl[24];
  logic [2:0]  pat[8];
  logic [31:0] vals[3];

  initial begin
    pat  = '{3'b001, 3'b110, 3'b100, 3'b011, 3'b010, 3'b101, 3'b101, 3'b010};
    vals = '{32'd0, 32'd5, 32'hFFFF_FFFF};
    for (int m = 0; m < 8; m++)
      for (int k = 0; k < 3; k++)
        tbl[m*3+k] = '{mode: 3'(m), rs1: vals[k], exp: pat[m][k]};

    // Reset state
    rst = 1'b1;
    drive(1'b1, 3'd0, 32'd0, 32'd5, 32'h40, 32'h8);
    tick();
    tick();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_flush", 64'(bus.flush), 64'd0);
    chk("rst_target", 64'(bus.out_target), 64'd0);
    chk("rst_stat", 64'(bus.stat_branches), 64'd0);
    rst = 1'b0;

    // Mode sweep with rs2 = 5
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, tbl[i].mode, tbl[i].rs1, 32'd5, $urandom, $urandom);
      tick();
      chk("sweep_taken", 64'(bus.out_taken), 64'(tbl[i].exp));
      chk("sweep_valid", 64'(bus.out_valid), 64'd1);
      idle(FC);
    end

    // Backward taken branch: target, one-cycle redirect, two-cycle flush
    drive(1'b1, 3'd0, 32'd0, 32'd5, 32'h100, 32'hFFFF_FFF0);
    tick();
    chk("bwd_target", 64'(bus.out_target), 64'h0F0);
    chk("bwd_redirect1", 64'(bus.redirect), 64'd1);
    chk("bwd_flush1", 64'(bus.flush), 64'd1);
    drive(1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0);
    tick();
    chk("bwd_redirect2", 64'(bus.redirect), 64'd0);
    chk("bwd_flush2", 64'(bus.flush), 64'd1);
    tick();
    chk("bwd_flush3", 64'(bus.flush), 64'd0);

    // Back-to-back taken branches: 2nd and 3rd squashed, 4th accepted
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b1, 3'd0, 32'd0, 32'd5, 32'h200, 32'h40);
    tick();
    chk("b2b_red1", 64'(bus.redirect), 64'd1);
    tick();
    chk("b2b_valid2", 64'(bus.out_valid), 64'd0);
    chk("b2b_red2", 64'(bus.redirect), 64'd0);
    tick();
    chk("b2b_valid3", 64'(bus.out_valid), 64'd0);
    chk("b2b_red3", 64'(bus.redirect), 64'd0);
    tick();
    chk("b2b_valid4", 64'(bus.out_valid), 64'd1);
    chk("b2b_red4", 64'(bus.redirect), 64'd1);
    chk("b2b_branches", 64'(bus.stat_branches), 64'd2);
    chk("b2b_taken", 64'(bus.stat_taken), 64'd2);
    idle(FC);

    // Target wrap-around on a not-taken branch
    drive(1'b1, 3'd1, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd8);
    tick();
    chk("wrap_target", 64'(bus.out_target), 64'h4);
    chk("wrap_taken", 64'(bus.out_taken), 64'd0);
    chk("wrap_red", 64'(bus.redirect), 64'd0);
    idle(1);

    // Reset in the first flush cycle abandons the window
    drive(1'b1, 3'd0, 32'd0, 32'd5, 32'h300, 32'h10);
    tick();
    chk("rstf_flush_pre", 64'(bus.flush), 64'd1);
    rst = 1'b1;
    tick();
    chk("rstf_flush", 64'(bus.flush), 64'd0);
    chk("rstf_red", 64'(bus.redirect), 64'd0);
    chk("rstf_branches", 64'(bus.stat_branches), 64'd0);
    chk("rstf_taken", 64'(bus.stat_taken), 64'd0);
    rst = 1'b0;
    drive(1'b1, 3'd7, 32'd5, 32'd5, 32'h400, 32'h20);
    tick();
    chk("rstf_accept", 64'(bus.out_valid), 64'd1);
    chk("rstf_br1", 64'(bus.stat_branches), 64'd1);
    idle(FC);

    // Randomized traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 4)) - 32'd2 : 32'($urandom);
      b = ($urandom_range(0, 2) == 0) ? a : 32'($urandom_range(0, 4)) - 32'd2;
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
            32'($urandom), 32'($urandom));
      tick();
    end
    rst = 1'b0;

    // Saturation of the 4-bit counters
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      drive(1'b1, 3'd4, 32'd9, 32'd9, 32'h1000, 32'h4);
      tick();
      idle(FC);
    end
    chk("sat_taken4", 64'(bus4.stat_taken), 64'd15);
    chk("sat_branches4", 64'(bus4.stat_branches), 64'd15);
    chk("sat_taken16", 64'(bus.stat_taken), 64'd20);
    drive(1'b1, 3'd4, 32'd9, 32'd9, 32'h1000, 32'h4);
    tick();
    chk("sat_hold_valid", 64'(bus4.out_valid), 64'd1);
    chk("sat_hold_taken4", 64'(bus4.stat_taken), 64'd15);
    idle(FC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
